// File: rtl/word_deserializer_if.sv
// rtl/word_deserializer_if.sv - serial-bit in / parallel-word out handshake bundle
interface word_deserializer_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [IDX_W:0]   bit_count;

  // deserializer side
  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid, bit_count
  );

  // bit producer / word consumer side
  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid, bit_count
  );
endinterface

// File: rtl/word_deserializer.sv
// rtl/word_deserializer.sv - bit-serial to parallel word assembler with valid/ready output
module word_deserializer #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_flush,
  word_deserializer_if.slave  s_bus
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W + 1)'(WIDTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_word;
  logic [IDX_W:0]   r_count;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [WIDTH-1:0] w_word_nxt;
  logic [IDX_W:0]   w_count_nxt;
  logic [IDX_W-1:0] w_pos;
  logic             w_bit_ready;
  logic             w_accept;

  // In HOLD the index is always 0, so w_pos is already pos(0) for the handoff bit.
  assign w_pos       = MSB_FIRST ? (IDX_LAST - r_idx) : r_idx;
  // A held word frees its slot in the same cycle it is consumed, so ready follows word_ready.
  assign w_bit_ready = !i_flush && ((r_state == S_FILL) || s_bus.word_ready);
  assign w_accept    = s_bus.bit_valid && w_bit_ready;

  assign s_bus.bit_ready  = w_bit_ready;
  assign s_bus.word_out   = r_word;
  assign s_bus.word_valid = (r_state == S_HOLD);
  assign s_bus.bit_count  = r_count;

  // next-state logic: flush first, then fill/accept or hold/handoff
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_state_nxt = S_FILL;
      w_idx_nxt   = '0;
      w_word_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            w_word_nxt[w_pos] = s_bus.bit_in;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt   = '0;
              w_state_nxt = S_HOLD;
              w_count_nxt = CNT_FULL;
            end else begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_count_nxt = {1'b0, r_idx} + CNT_ONE;
            end
          end
        end
        S_HOLD: begin
          if (s_bus.word_ready) begin
            w_state_nxt = S_FILL;
            w_word_nxt  = '0;
            w_idx_nxt   = '0;
            w_count_nxt = '0;
            // handoff and first bit of the next word in the same cycle
            if (s_bus.bit_valid) begin
              w_word_nxt[w_pos] = s_bus.bit_in;
              w_idx_nxt         = IDX_W'(1);
              w_count_nxt       = CNT_ONE;
            end
          end
        end
        default: begin
          w_state_nxt = S_FILL;
          w_idx_nxt   = '0;
          w_word_nxt  = '0;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_word  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_word_deserializer.sv
// tb/tb_word_deserializer.sv - self-checking bench for word_deserializer
module tb_word_deserializer;

  logic clk;
  logic reset_n;
  logic flush;

  word_deserializer_if #(.WIDTH(32), .IDX_W(5)) m  ();
  word_deserializer_if #(.WIDTH(32), .IDX_W(5)) m2 ();

  word_deserializer #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b0)) u_dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_flush   (flush),
    .s_bus     (m)
  );

  word_deserializer #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b1)) u_dut_msb (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_flush   (1'b0),
    .s_bus     (m2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] sb[$];
  int pop_cyc[$];

  typedef struct {
    logic [31:0] data;
    int          gap_pct;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter for throughput measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: pop on every completed word handshake
  always @(negedge clk) begin
    if (reset_n && !flush && m.word_valid && m.word_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got word 0x%08h expected none", m.word_out);
      end else begin
        check("sb_word", m.word_out, sb.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit done;
    done = 1'b0;
    m.bit_in    = b;
    m.bit_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (m.bit_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    m.bit_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_bit_timeout: got no ready expected ready within 100 cycles");
    end
  endtask

  task automatic send_word(input logic [31:0] data, input int nbits, input int gap_pct, input bit push);
    if (push) sb.push_back(data);
    for (int i = 0; i < nbits; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        m.bit_valid = 1'b0;
        step();
        check("gap_count", 32'(m.bit_count), 32'(i));
      end
      send_bit(data[i]);
      check("bit_count", 32'(m.bit_count), (i == 31) ? 32'd32 : 32'(i + 1));
    end
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 0,  32'hDEADBEEF};
    vecs[1] = '{32'hA5A55A5A, 50, 32'hA5A55A5A};
    vecs[2] = '{32'h00000000, 0,  32'h00000000};
    vecs[3] = '{32'hFFFFFFFF, 30, 32'hFFFFFFFF};
    vecs[4] = '{32'h80000001, 0,  32'h80000001};

    reset_n = 1'b0;
    flush   = 1'b0;
    m.bit_in = 1'b0;  m.bit_valid = 1'b0;  m.word_ready = 1'b1;
    m2.bit_in = 1'b0; m2.bit_valid = 1'b0; m2.word_ready = 1'b1;
    step();
    step();
    check("rst_word_out", m.word_out, 32'h0);
    check("rst_word_valid", 32'(m.word_valid), 32'd0);
    check("rst_bit_count", 32'(m.bit_count), 32'd0);
    check("rst_bit_ready", 32'(m.bit_ready), 32'd1);
    reset_n = 1'b1;
    step();

    // table-driven words, LSB first, word_ready held high
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].data, 32, vecs[v].gap_pct, 1'b1);
      check("vec_valid", 32'(m.word_valid), 32'd1);
      check("vec_word", m.word_out, vecs[v].exp);
      check("vec_count_full", 32'(m.bit_count), 32'd32);
      step();
      check("vec_valid_one_cycle", 32'(m.word_valid), 32'd0);
      check("vec_word_cleared", m.word_out, 32'h0);
      check("vec_count_zero", 32'(m.bit_count), 32'd0);
    end

    // backpressure: hold the word 10 cycles while a bit is offered
    m.word_ready = 1'b0;
    send_word(32'h0000FFFF, 32, 0, 1'b1);
    m.bit_in    = 1'b1;
    m.bit_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("bp_bit_ready", 32'(m.bit_ready), 32'd0);
      step();
      check("bp_word", m.word_out, 32'h0000FFFF);
      check("bp_valid", 32'(m.word_valid), 32'd1);
      check("bp_count", 32'(m.bit_count), 32'd32);
    end
    m.word_ready = 1'b1;
    send_word(32'h0F0F0F0F, 32, 0, 1'b1);
    check("bp_next_word", m.word_out, 32'h0F0F0F0F);
    step();

    // back-to-back words, continuous bit_valid
    pop_cyc.delete();
    send_word(32'h12345678, 32, 0, 1'b1);
    send_word(32'h9ABCDEF0, 32, 0, 1'b1);
    check("b2b_word2", m.word_out, 32'h9ABCDEF0);
    step();
    check("b2b_pops", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) check("b2b_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd32);

    // flush a partial word, then a held word
    send_word(32'h00001FFF, 13, 0, 1'b0);
    check("fl_count13", 32'(m.bit_count), 32'd13);
    flush = 1'b1;
    m.bit_in = 1'b1;
    m.bit_valid = 1'b1;
    #1;
    check("fl_bit_ready", 32'(m.bit_ready), 32'd0);
    step();
    flush = 1'b0;
    m.bit_valid = 1'b0;
    check("fl_count0", 32'(m.bit_count), 32'd0);
    check("fl_word0", m.word_out, 32'h0);
    check("fl_valid0", 32'(m.word_valid), 32'd0);
    send_word(32'hCAFEF00D, 32, 0, 1'b1);
    check("fl_clean_word", m.word_out, 32'hCAFEF00D);
    step();
    m.word_ready = 1'b0;
    send_word(32'h55555555, 32, 0, 1'b0);
    check("flh_valid", 32'(m.word_valid), 32'd1);
    flush = 1'b1;
    m.word_ready = 1'b1;
    step();
    flush = 1'b0;
    check("flh_valid0", 32'(m.word_valid), 32'd0);
    check("flh_word0", m.word_out, 32'h0);
    check("flh_count0", 32'(m.bit_count), 32'd0);

    // reset mid-word and in HOLD
    send_word(32'hFFFFFFFF, 10, 0, 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rmid_word", m.word_out, 32'h0);
    check("rmid_count", 32'(m.bit_count), 32'd0);
    check("rmid_valid", 32'(m.word_valid), 32'd0);
    #1;
    check("rmid_ready", 32'(m.bit_ready), 32'd1);
    step();
    m.word_ready = 1'b0;
    send_word(32'h3C3C3C3C, 32, 0, 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m.word_ready = 1'b1;
    check("rhold_valid", 32'(m.word_valid), 32'd0);
    check("rhold_word", m.word_out, 32'h0);
    check("rhold_count", 32'(m.bit_count), 32'd0);
    step();

    // MSB-first instance: 1, thirty 0s, 1 then 1, thirty-one 0s
    for (int i = 0; i < 32; i++) begin
      m2.bit_in = (i == 0 || i == 31);
      m2.bit_valid = 1'b1;
      step();
    end
    m2.bit_valid = 1'b0;
    check("msb_valid", 32'(m2.word_valid), 32'd1);
    check("msb_word_a", m2.word_out, 32'h80000001);
    for (int i = 0; i < 32; i++) begin
      m2.bit_in = (i == 0);
      m2.bit_valid = 1'b1;
      step();
    end
    m2.bit_valid = 1'b0;
    check("msb_word_b", m2.word_out, 32'h80000000);
    step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
